// File: rtl/sc_edge_frame_ctrl.sv
// Frame sequencer for the stochastic-computing edge-detector array.
// Drives the shared SNG random stream, the sel bitstream and the counter bank.
module sc_edge_frame_ctrl #(
    parameter int          LFSR_W   = 8,
    parameter int          LEN_W    = 8,
    parameter int          PIPE_LAT = 1,
    parameter logic [7:0]  RND_SEED = 8'h01,
    parameter logic [7:0]  SEL_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  stream_len,
    output logic              busy,
    output logic [LFSR_W-1:0] rnd,
    output logic              sng_en,
    output logic              sel,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              done_valid,
    input  logic              done_ready
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    localparam logic [LFSR_W-1:0] RS   = LFSR_W'(RND_SEED);
    localparam logic [LFSR_W-1:0] SS   = LFSR_W'(SEL_SEED);
    localparam logic [LEN_W:0]    FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0]    DLAT = (LEN_W+1)'(PIPE_LAT);
    localparam int T1 = (LFSR_W == 16) ? 13 : 5;
    localparam int T2 = (LFSR_W == 16) ? 12 : 4;
    localparam int T3 = (LFSR_W == 16) ? 10 : 3;

    function automatic logic [LFSR_W-1:0] step(input logic [LFSR_W-1:0] r);
        return {r[LFSR_W-2:0], r[LFSR_W-1] ^ r[T1] ^ r[T2] ^ r[T3]};
    endfunction

    state_t            state;
    logic [LFSR_W-1:0] rl;
    logic [LFSR_W-1:0] sl;
    logic [LEN_W:0]    cnt;
    logic [LEN_W:0]    len_q;

    // rl/sl hold the value to present on the next RUN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sng_en     <= 1'b0;
            sel        <= 1'b0;
            acc_clr    <= 1'b0;
            done_valid <= 1'b0;
            rnd        <= '0;
            rl         <= RS;
            sl         <= SS;
            cnt        <= '0;
            len_q      <= '0;
        end else begin
            acc_clr <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                sng_en     <= 1'b0;
                sel        <= 1'b0;
                done_valid <= 1'b0;
                rnd        <= '0;
                cnt        <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= CLEAR;
                            busy    <= 1'b1;
                            acc_clr <= 1'b1;
                            len_q   <= (stream_len == '0) ? FULL
                                                          : {1'b0, stream_len};
                        end
                    end
                    CLEAR: begin
                        state  <= RUN;
                        sng_en <= 1'b1;
                        rnd    <= RS;
                        rl     <= step(RS);
                        sel    <= SS[0];
                        sl     <= step(SS);
                        cnt    <= 1;
                    end
                    RUN: begin
                        if (cnt == len_q) begin
                            sng_en <= 1'b0;
                            cnt    <= 1;
                            if (PIPE_LAT > 0) begin
                                state <= DRAIN;
                            end else begin
                                state      <= DONE;
                                done_valid <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            rnd <= rl;
                            rl  <= step(rl);
                            sel <= sl[0];
                            sl  <= step(sl);
                        end
                    end
                    DRAIN: begin
                        if (cnt == DLAT) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (done_ready) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done_valid <= 1'b0;
                            rnd        <= '0;
                            sel        <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    generate
        if (PIPE_LAT == 0) begin : g_nodly
            assign acc_en = sng_en;
        end else begin : g_dly
            logic [PIPE_LAT-1:0] dly;
            logic                kill;
            assign kill = (state == CLEAR) || (abort && state != IDLE);
            // delay line aligns acc_en with the edge datapath output
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dly <= '0;
                end else if (kill) begin
                    dly <= '0;
                end else begin
                    dly[0] <= sng_en;
                    for (int i = 1; i < PIPE_LAT; i++)
                        dly[i] <= dly[i-1];
                end
            end
            assign acc_en = dly[PIPE_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_sc_edge_frame_ctrl.sv
// Directed bench for sc_edge_frame_ctrl (PIPE_LAT=1 and PIPE_LAT=0 instances).
module tb_sc_edge_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, done_ready;
    logic [7:0] stream_len;
    logic       busy, sng_en, sel, acc_clr, acc_en, done_valid;
    logic [7:0] rnd;

    logic       start0, abort0, ready0;
    logic [7:0] len0;
    logic       busy0, sng_en0, sel0, acc_clr0, acc_en0, dv0;
    logic [7:0] rnd0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sc_edge_frame_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .stream_len(stream_len), .busy(busy), .rnd(rnd), .sng_en(sng_en),
        .sel(sel), .acc_clr(acc_clr), .acc_en(acc_en),
        .done_valid(done_valid), .done_ready(done_ready)
    );

    sc_edge_frame_ctrl #(.PIPE_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .stream_len(len0), .busy(busy0), .rnd(rnd0), .sng_en(sng_en0),
        .sel(sel0), .acc_clr(acc_clr0), .acc_en(acc_en0),
        .done_valid(dv0), .done_ready(ready0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] st(input logic [7:0] r);
        return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sng"}, sng_en, 0);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_clr"}, acc_clr, 0);
        chk({tag, "_acc"}, acc_en, 0);
        chk({tag, "_dv"}, done_valid, 0);
        chk({tag, "_rnd"}, rnd, 0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_valid !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk(tag, done_valid, 1);
    endtask

    logic [7:0] rv [0:299];
    logic [7:0] ra [0:1][0:5];
    logic       sa [0:1][0:5];
    bit         seen [0:255];

    task automatic cap(input int f);
        int n = 0;
        stream_len = 8'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (sng_en === 1'b1 && n < 6) begin
                ra[f][n] = rnd;
                sa[f][n] = sel;
                n++;
            end
        end
        chk("cap_len", n, 6);
    endtask

    initial begin
        logic [7:0] m, s;
        int ns, na, nd, mism, dup;

        reset = 1'b0; start = 1'b0; abort = 1'b0; done_ready = 1'b0;
        stream_len = 8'd0;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1; len0 = 8'd0;
        tick();
        chk_zero("rst");
        chk("rst0_busy", busy0, 0);
        reset = 1'b1;
        tick();

        // L=4 frame, consumer stalls 5 cycles, start in DONE ignored
        stream_len = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        stream_len = 8'd9;
        for (int c = 1; c <= 11; c++) begin
            chk($sformatf("f4_clr_c%0d", c), acc_clr, c == 1);
            chk($sformatf("f4_sng_c%0d", c), sng_en, c >= 2 && c <= 5);
            chk($sformatf("f4_acc_c%0d", c), acc_en, c >= 3 && c <= 6);
            chk($sformatf("f4_busy_c%0d", c), busy, 1);
            chk($sformatf("f4_dv_c%0d", c), done_valid, c >= 7);
            if (c >= 2 && c <= 5)
                chk($sformatf("f4_rnd_c%0d", c), rnd, 32'd1 << (c - 2));
            if (c == 6)
                chk("f4_rnd_drain", rnd, 8'h08);
            start = (c == 8);
            tick();
        end
        start = 1'b0;
        chk("hs_dv", done_valid, 1);
        done_ready = 1'b1;
        tick();
        chk("hs_idle_busy", busy, 0);
        chk("hs_idle_dv", done_valid, 0);
        tick();
        chk("no_queue_busy", busy, 0);

        // L=0 -> 256-cycle frame, full LFSR period
        stream_len = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ns = 0; na = 0; nd = 0;
        for (int i = 0; i < 270; i++) begin
            tick();
            if (sng_en === 1'b1 && ns < 300) begin
                rv[ns] = rnd;
                ns++;
            end
            if (acc_en === 1'b1) na++;
            if (done_valid === 1'b1) nd++;
        end
        chk("l256_sng", ns, 256);
        chk("l256_acc", na, 256);
        chk("l256_done", nd, 1);
        m = 8'h01; mism = 0; dup = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 255 && i < ns; i++) begin
            if (rv[i] !== m) mism++;
            if (rv[i] === 8'h00 || seen[rv[i]]) dup++;
            else seen[rv[i]] = 1'b1;
            m = st(m);
        end
        chk("l256_seq", mism, 0);
        chk("l256_uniq", dup, 0);
        chk("l256_wrap", (ns >= 256) ? rv[255] : 8'hxx, 8'h01);

        // back-to-back L=6 frames reproduce the same streams
        cap(0);
        cap(1);
        mism = 0;
        m = 8'h01; s = 8'hA5;
        for (int i = 0; i < 6; i++) begin
            if (ra[0][i] !== ra[1][i] || sa[0][i] !== sa[1][i]) mism++;
            if (ra[0][i] !== m || sa[0][i] !== s[0]) mism++;
            m = st(m);
            s = st(s);
        end
        chk("reseed_mism", mism, 0);

        // start with abort in IDLE: start wins
        stream_len = 8'd8;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 1);
        chk("sa_clr", acc_clr, 1);
        tick();
        tick();
        tick();
        chk("ab_run3_rnd", rnd, 8'h04);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_zero("ab");
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_valid !== 1'b0 || busy !== 1'b0) nd++;
        end
        chk("ab_quiet", nd, 0);
        stream_len = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk($sformatf("ab_new_rnd%0d", c), rnd, 32'd1 << (c - 2));
        end
        wait_done("ab_new_done");
        tick();

        // PIPE_LAT=0 instance, L=3
        len0 = 8'd3;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("p0_sng_c%0d", c), sng_en0, c >= 2 && c <= 4);
            chk($sformatf("p0_acc_c%0d", c), acc_en0, c >= 2 && c <= 4);
            chk($sformatf("p0_dv_c%0d", c), dv0, c == 5);
            chk($sformatf("p0_busy_c%0d", c), busy0, c <= 5);
            tick();
        end

        // asynchronous reset mid-RUN
        stream_len = 8'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mr_sng_pre", sng_en, 1);
        #2 reset = 1'b0;
        #1 chk_zero("mr");
        #2 reset = 1'b1;
        tick();
        chk("mr_idle_busy", busy, 0);
        tick();
        chk("mr_idle_sng", sng_en, 0);
        chk("mr_idle_dv", done_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
